lz_codec_sched: RTL and testbench
=================================

// Module: lz_codec_sched
// PURPOSE
//   Shares one LZ77 codec core (encode/decode engine, 30-char frame buffer, code_valid burst loader) between an
//   encode requester and a decode requester. Round-robin arbitration; captures a whole frame into a local buffer,
//   then bursts it to the core gap-free (core ends its load on the first code_valid gap). Sequences mode, waits for
//   core_done, and recovers via watchdog. Sits between the host stream ports and the codec core.
// PARAMETERS
//   FRAME_MAX  30    max beats per job (core buffer depth); legal job length 1..FRAME_MAX
//   LEN_W      5     width of job-length fields/counters
//   TIMEOUT    1023  max cycles in RUN before abort
// PORTS
//   clk        in   1   clock, rising edge
//   reset      in   1   asynchronous, active-high
//   enc_req    in   1   encode job request; hold until enc_done/err
//   enc_num    in   5   beats in encode job, sampled at grant
//   enc_valid  in   1   encode beat valid
//   enc_char   in   8   encode beat character
//   enc_ready  out  1   encode beat accepted when valid&ready
//   enc_gnt    out  1   encode owns core (grant to done)
//   enc_done   out  1   1-cycle pulse, encode job complete
//   dec_req    in   1   decode job request
//   dec_num    in   5   beats (triples) in decode job
//   dec_valid  in   1   decode beat valid
//   dec_pos    in   4   triple offset
//   dec_len    in   4   triple match length
//   dec_char   in   8   triple next char
//   dec_ready  out  1   decode beat accepted when valid&ready
//   dec_gnt    out  1   decode owns core
//   dec_done   out  1   1-cycle pulse, decode job complete
//   core_mode  out  1   0=encode 1=decode; stable from BURST until IDLE
//   core_code_valid out 1 burst beat valid, contiguous for num cycles
//   core_code_pos   out 4 beat pos (0 for encode)
//   core_code_len   out 4 beat len (0 for encode)
//   core_chardata   out 8 beat char
//   core_abort out  1   1-cycle pulse: core must return to load state
//   core_done  in   1   core finished job (pulse)
//   err_len    out  1   level: candidate requester has num=0 or >FRAME_MAX
//   err_tmo    out  1   1-cycle pulse on watchdog abort
// BEHAVIOUR
//   Reset: all outputs 0; state IDLE; rr_last=DEC (encode wins first tie); counters 0. Reset mid-job drops job, no done.
//   FSM IDLE->LOAD->BURST->RUN->DONE->IDLE.
//   IDLE: candidates = req && legal num. Both -> the one != rr_last; one -> it. Grant registered: gnt high next
//     cycle, num latched, state LOAD. Illegal num: requester skipped, err_len high while its req high.
//   LOAD: ready=1 for granted side only; each valid&ready beat written to buffer[cnt], cnt++. At cnt==num ready drops
//     same cycle as last beat accept -> BURST. Requester drops req in LOAD: discard, gnt low, IDLE, no core activity.
//   BURST: reads buffer[0..num-1], core_code_valid=1 for exactly num consecutive cycles, data registered
//     (1-cycle read latency hidden). Then RUN; req drops from here on are ignored.
//   RUN: wait core_done; watchdog counts cycles; at TIMEOUT -> core_abort + err_tmo pulse, gnt low, rr_last
//     updated, IDLE, no done pulse.
//   DONE: done pulse 1 cycle for owner, gnt low same cycle, rr_last=owner, IDLE. New grant earliest next cycle.
//   core_done outside RUN ignored. Non-owner ready always 0. Counters LEN_W bits, never wrap (num<=FRAME_MAX).
// STRUCTURE
//   Package lz_pkg: FRAME_MAX, LEN_W, MODE_ENC/MODE_DEC, state encodings (IDLE/LOAD/BURST/RUN/DONE).
//   Sub-module lz_frame_buf: FRAME_MAX x 16b (pos,len,char), 1 write + 1 registered read port.
//   Top holds arbiter, FSM, beat/burst counters, watchdog.
// TESTING
//   Enc only, num=5, chars "ABCAB" w/ valid gaps -> core_code_valid 5 contiguous cycles "ABCAB", mode 0, enc_done after core_done.
//   enc_req&dec_req same cycle after reset -> enc_gnt first; after enc_done dec_gnt next cycle; then enc again.
//   Dec num=3 triples (0,0,'a'),(0,1,'b'),(2,2,'c') -> burst pos/len/char exact, core_mode=1, dec_done once.
//   enc_num=0 and 31 -> no grant, err_len=1; dec_req concurrently still granted.
//   core_done withheld -> core_abort+err_tmo pulse at RUN cycle 1023, no enc_done, IDLE after.
//   Reset asserted mid-BURST -> all outputs 0 immediately; enc_req dropped in LOAD -> no core_code_valid ever.

Source files
------------

// File: rtl/lz_pkg.sv
// rtl/lz_pkg.sv - shared constants, types and helpers for the LZ codec scheduler
package lz_pkg;

  localparam int FRAME_MAX = 30;
  localparam int LEN_W     = 5;
  localparam int TIMEOUT   = 1023;
  localparam int WD_W      = $clog2(TIMEOUT + 1);

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_BURST = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // One buffered beat: decode triple, or a bare character for encode (pos/len zero)
  typedef struct packed {
    logic [3:0] pos;
    logic [3:0] len;
    logic [7:0] chr;
  } beat_t;

  // A job length is usable only if it fits the core buffer and is non-empty
  function automatic logic len_ok(input logic [LEN_W-1:0] num);
    return (num != '0) && (num <= LEN_W'(FRAME_MAX));
  endfunction

endpackage

// File: rtl/lz_frame_buf.sv
// rtl/lz_frame_buf.sv - frame buffer, one write port and one registered read port
module lz_frame_buf
  import lz_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [LEN_W-1:0] wr_addr,
  input  beat_t            wr_data,
  input  logic             rd_en,
  input  logic [LEN_W-1:0] rd_addr,
  output beat_t            rd_data
);

  beat_t mem [FRAME_MAX];

  // Capture beats from the requester; storage needs no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read; cleared on reset so the core-facing data reads zero
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/lz_codec_sched.sv
// rtl/lz_codec_sched.sv - round-robin job scheduler in front of a shared LZ77 codec core
module lz_codec_sched
  import lz_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enc_req,
  input  logic [4:0] enc_num,
  input  logic       enc_valid,
  input  logic [7:0] enc_char,
  output logic       enc_ready,
  output logic       enc_gnt,
  output logic       enc_done,
  input  logic       dec_req,
  input  logic [4:0] dec_num,
  input  logic       dec_valid,
  input  logic [3:0] dec_pos,
  input  logic [3:0] dec_len,
  input  logic [7:0] dec_char,
  output logic       dec_ready,
  output logic       dec_gnt,
  output logic       dec_done,
  output logic       core_mode,
  output logic       core_code_valid,
  output logic [3:0] core_code_pos,
  output logic [3:0] core_code_len,
  output logic [7:0] core_chardata,
  output logic       core_abort,
  input  logic       core_done,
  output logic       err_len,
  output logic       err_tmo
);

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);
  localparam logic [WD_W-1:0]  WD_ONE  = WD_W'(1);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

  logic [2:0]       state;
  logic             owner;
  logic             rr_last;
  logic [LEN_W-1:0] num_q;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] bcnt;
  logic [WD_W-1:0]  wd;
  logic             valid_q;

  logic  cand_e, cand_d, grant_any, grant_dec, rr_eff;
  logic  owner_req, owner_valid, load_acc, rd_en, tmo, busy;
  beat_t wr_beat, rd_beat;

  // Arbitration: in DONE the finishing owner is still holding req, so it is
  // excluded and the other side can be granted back-to-back
  always_comb begin
    cand_e    = enc_req && len_ok(enc_num) && !(state == S_DONE && owner == MODE_ENC);
    cand_d    = dec_req && len_ok(dec_num) && !(state == S_DONE && owner == MODE_DEC);
    rr_eff    = (state == S_DONE) ? owner : rr_last;
    grant_any = (state == S_IDLE || state == S_DONE) && (cand_e || cand_d);
    grant_dec = cand_d && (!cand_e || rr_eff == MODE_ENC);
  end

  // Owner-side datapath selection and per-state strobes
  always_comb begin
    owner_req   = (owner == MODE_DEC) ? dec_req   : enc_req;
    owner_valid = (owner == MODE_DEC) ? dec_valid : enc_valid;
    load_acc    = (state == S_LOAD) && owner_valid;
    rd_en       = (state == S_BURST) && (bcnt < num_q);
    tmo         = (state == S_RUN) && !core_done && (wd == WD_LAST);
    busy        = (state == S_LOAD) || (state == S_BURST) || (state == S_RUN);
    wr_beat     = '0;
    if (owner == MODE_DEC) begin
      wr_beat.pos = dec_pos;
      wr_beat.len = dec_len;
      wr_beat.chr = dec_char;
    end else begin
      wr_beat.chr = enc_char;
    end
  end

  // Job sequencer: grant, capture, burst, wait for the core, retire or abort
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      owner   <= MODE_ENC;
      rr_last <= MODE_DEC;
      num_q   <= '0;
      cnt     <= '0;
      bcnt    <= '0;
      wd      <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rd_en;
      case (state)
        S_IDLE: begin
          if (grant_any) begin
            owner <= grant_dec;
            num_q <= grant_dec ? dec_num : enc_num;
            cnt   <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (!owner_req) begin
            cnt   <= '0;
            state <= S_IDLE;
          end else if (load_acc) begin
            cnt <= cnt + CNT_ONE;
            if (cnt == num_q - CNT_ONE) begin
              bcnt  <= '0;
              state <= S_BURST;
            end
          end
        end
        S_BURST: begin
          // bcnt runs 0..num: reads issue for 0..num-1, last beat leaves the register at num
          if (bcnt == num_q) begin
            wd    <= '0;
            state <= S_RUN;
          end else begin
            bcnt <= bcnt + CNT_ONE;
          end
        end
        S_RUN: begin
          if (core_done) begin
            state <= S_DONE;
          end else if (tmo) begin
            rr_last <= owner;
            state   <= S_IDLE;
          end else begin
            wd <= wd + WD_ONE;
          end
        end
        S_DONE: begin
          rr_last <= owner;
          if (grant_any) begin
            owner <= grant_dec;
            num_q <= grant_dec ? dec_num : enc_num;
            cnt   <= '0;
            state <= S_LOAD;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  lz_frame_buf u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (load_acc),
    .wr_addr (cnt),
    .wr_data (wr_beat),
    .rd_en   (rd_en),
    .rd_addr (bcnt),
    .rd_data (rd_beat)
  );

  // Requester- and core-facing outputs, all derived from reset-cleared state
  always_comb begin
    enc_gnt         = busy && (owner == MODE_ENC);
    dec_gnt         = busy && (owner == MODE_DEC);
    enc_ready       = (state == S_LOAD) && (owner == MODE_ENC);
    dec_ready       = (state == S_LOAD) && (owner == MODE_DEC);
    enc_done        = (state == S_DONE) && (owner == MODE_ENC);
    dec_done        = (state == S_DONE) && (owner == MODE_DEC);
    core_mode       = (state != S_IDLE) && (owner == MODE_DEC);
    core_code_valid = valid_q;
    core_code_pos   = rd_beat.pos;
    core_code_len   = rd_beat.len;
    core_chardata   = rd_beat.chr;
    core_abort      = tmo;
    err_tmo         = tmo;
    err_len         = (enc_req && !len_ok(enc_num)) || (dec_req && !len_ok(dec_num));
  end

endmodule

// File: tb/tb_lz_codec_sched.sv
// tb/tb_lz_codec_sched.sv - self-checking bench for lz_codec_sched
module tb_lz_codec_sched;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enc_req = 1'b0, enc_valid = 1'b0;
  logic [4:0] enc_num = '0;
  logic [7:0] enc_char = '0;
  logic       dec_req = 1'b0, dec_valid = 1'b0;
  logic [4:0] dec_num = '0;
  logic [3:0] dec_pos = '0, dec_len = '0;
  logic [7:0] dec_char = '0;
  logic       core_done = 1'b0;
  logic       enc_ready, enc_gnt, enc_done, dec_ready, dec_gnt, dec_done;
  logic       core_mode, core_code_valid, core_abort, err_len, err_tmo;
  logic [3:0] core_code_pos, core_code_len;
  logic [7:0] core_chardata;

  lz_codec_sched dut (
    .clk(clk), .reset(reset),
    .enc_req(enc_req), .enc_num(enc_num), .enc_valid(enc_valid), .enc_char(enc_char),
    .enc_ready(enc_ready), .enc_gnt(enc_gnt), .enc_done(enc_done),
    .dec_req(dec_req), .dec_num(dec_num), .dec_valid(dec_valid), .dec_pos(dec_pos),
    .dec_len(dec_len), .dec_char(dec_char), .dec_ready(dec_ready), .dec_gnt(dec_gnt),
    .dec_done(dec_done), .core_mode(core_mode), .core_code_valid(core_code_valid),
    .core_code_pos(core_code_pos), .core_code_len(core_code_len),
    .core_chardata(core_chardata), .core_abort(core_abort), .core_done(core_done),
    .err_len(err_len), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;
  int enc_done_cnt = 0;
  int dec_done_cnt = 0;
  int mark;
  logic [16:0] beat_q[$];
  int          beat_cyc[$];
  logic [15:0] job [30];

  typedef struct {
    logic       er;
    logic [4:0] en;
    logic       dr;
    logic [4:0] dn;
    logic       x_err;
    logic       x_eg;
    logic       x_dg;
  } vec_t;
  vec_t vt [9];

  always @(posedge clk) cyc <= cyc + 1;

  // Record every core beat (mode,pos,len,char) with its cycle, and count done pulses
  always @(negedge clk) begin
    if (core_code_valid === 1'b1) begin
      beat_q.push_back({core_mode, core_code_pos, core_code_len, core_chardata});
      beat_cyc.push_back(cyc);
    end
    if (enc_done === 1'b1) enc_done_cnt <= enc_done_cnt + 1;
    if (dec_done === 1'b1) dec_done_cnt <= dec_done_cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enc_req = 1'b0; dec_req = 1'b0; enc_valid = 1'b0; dec_valid = 1'b0; core_done = 1'b0;
    nxt(); nxt();
    reset = 1'b0;
    nxt();
  endtask

  task automatic drive_beat(input bit is_dec, input logic v, input logic [15:0] d);
    if (is_dec) begin
      dec_valid = v; dec_pos = d[15:12]; dec_len = d[11:8]; dec_char = d[7:0];
    end else begin
      enc_valid = v; enc_char = d[7:0];
    end
  endtask

  // Wait for grant, then load n beats from job[] with a valid gap before every odd beat
  task automatic feed_job(input bit is_dec, input int n);
    int g;
    g = 0;
    while (((is_dec ? dec_gnt : enc_gnt) !== 1'b1) && g < 20) begin nxt(); g++; end
    chk($sformatf("gnt_side%0d", is_dec), is_dec ? dec_gnt : enc_gnt, 1);
    chk($sformatf("gnt_other%0d", is_dec), is_dec ? enc_gnt : dec_gnt, 0);
    mark = beat_q.size();
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 1) begin drive_beat(is_dec, 1'b0, 16'h0); nxt(); end
      chk($sformatf("ready%0d_beat%0d", is_dec, i), is_dec ? dec_ready : enc_ready, 1);
      chk($sformatf("other_ready%0d_beat%0d", is_dec, i), is_dec ? enc_ready : dec_ready, 0);
      drive_beat(is_dec, 1'b1, job[i]);
      nxt();
    end
    drive_beat(is_dec, 1'b0, 16'h0);
    chk($sformatf("ready_after_load%0d", is_dec), is_dec ? dec_ready : enc_ready, 0);
  endtask

  // Wait for the burst and compare it beat by beat, including contiguity
  task automatic check_burst(input bit is_dec, input int n);
    int g;
    logic [16:0] e;
    g = 0;
    while (beat_q.size() < mark + n && g < 80) begin nxt(); g++; end
    chk($sformatf("burst_count%0d", is_dec), beat_q.size() - mark, n);
    if (beat_q.size() >= mark + n) begin
      chk($sformatf("burst_contig%0d", is_dec), beat_cyc[mark+n-1] - beat_cyc[mark], n - 1);
      for (int i = 0; i < n; i++) begin
        e = {is_dec, job[i]};
        chk($sformatf("burst%0d_beat%0d", is_dec, i), beat_q[mark+i], e);
      end
    end
  endtask

  // Hold off, pulse core_done once, and check the done/grant handover
  task automatic finish_job(input bit is_dec, input int delay);
    nxt();
    chk($sformatf("no_extra_beats%0d", is_dec), core_code_valid, 0);
    repeat (delay) nxt();
    chk($sformatf("done_early%0d", is_dec), is_dec ? dec_done : enc_done, 0);
    core_done = 1'b1;
    nxt();
    core_done = 1'b0;
    chk($sformatf("done_pulse%0d", is_dec), is_dec ? dec_done : enc_done, 1);
    chk($sformatf("gnt_at_done%0d", is_dec), is_dec ? dec_gnt : enc_gnt, 0);
    chk($sformatf("mode_at_done%0d", is_dec), core_mode, is_dec);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int d0, last;
    int g;

    vt[0] = '{1'b1, 5'd5,  1'b0, 5'd0,  1'b0, 1'b1, 1'b0};
    vt[1] = '{1'b1, 5'd0,  1'b0, 5'd0,  1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b1, 5'd31, 1'b1, 5'd3,  1'b1, 1'b0, 1'b1};
    vt[3] = '{1'b1, 5'd0,  1'b1, 5'd3,  1'b1, 1'b0, 1'b1};
    vt[4] = '{1'b1, 5'd30, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0};
    vt[5] = '{1'b0, 5'd0,  1'b1, 5'd1,  1'b0, 1'b0, 1'b1};
    vt[6] = '{1'b1, 5'd4,  1'b1, 5'd4,  1'b0, 1'b1, 1'b0};
    vt[7] = '{1'b0, 5'd7,  1'b0, 5'd7,  1'b0, 1'b0, 1'b0};
    vt[8] = '{1'b0, 5'd0,  1'b1, 5'd31, 1'b1, 1'b0, 1'b0};

    // Reset state
    nxt();
    chk("reset_outs", {enc_ready, enc_gnt, enc_done, dec_ready, dec_gnt, dec_done, core_mode,
                       core_code_valid, core_code_pos, core_code_len, core_chardata,
                       core_abort, err_len, err_tmo}, 0);
    reset = 1'b0;
    nxt();

    // Arbitration / length-check table; every grant is discarded by dropping req in LOAD
    mark = beat_q.size();
    for (int i = 0; i < 9; i++) begin
      enc_req = vt[i].er; enc_num = vt[i].en; dec_req = vt[i].dr; dec_num = vt[i].dn;
      nxt();
      chk($sformatf("tbl%0d_err_len", i), err_len, vt[i].x_err);
      chk($sformatf("tbl%0d_enc_gnt", i), enc_gnt, vt[i].x_eg);
      chk($sformatf("tbl%0d_dec_gnt", i), dec_gnt, vt[i].x_dg);
      enc_req = 1'b0; dec_req = 1'b0;
      nxt(); nxt();
      chk($sformatf("tbl%0d_released", i), {enc_gnt, dec_gnt}, 0);
    end
    chk("discard_no_burst", beat_q.size() - mark, 0);

    // Encode-only job "ABCAB" with valid gaps
    d0 = enc_done_cnt;
    job[0] = 16'h0041; job[1] = 16'h0042; job[2] = 16'h0043; job[3] = 16'h0041; job[4] = 16'h0042;
    enc_req = 1'b1; enc_num = 5'd5;
    feed_job(1'b0, 5);
    check_burst(1'b0, 5);
    finish_job(1'b0, 3);
    enc_req = 1'b0;
    nxt();
    chk("enc_done_once", enc_done_cnt - d0, 1);
    chk("enc_idle_after", {enc_gnt, enc_done}, 0);

    // Simultaneous requests after reset: enc, then dec, then enc again
    do_reset();
    d0 = dec_done_cnt;
    job[0] = 16'h005A;
    enc_req = 1'b1; enc_num = 5'd1; dec_req = 1'b1; dec_num = 5'd3;
    feed_job(1'b0, 1);
    check_burst(1'b0, 1);
    finish_job(1'b0, 2);
    enc_req = 1'b0;
    job[0] = 16'h0061; job[1] = 16'h0162; job[2] = 16'h2263;
    nxt();
    chk("dec_gnt_after_enc_done", dec_gnt, 1);
    enc_req = 1'b1; enc_num = 5'd2;
    feed_job(1'b1, 3);
    check_burst(1'b1, 3);
    finish_job(1'b1, 2);
    dec_req = 1'b0;
    job[0] = 16'h0058; job[1] = 16'h0059;
    nxt();
    chk("enc_gnt_after_dec_done", enc_gnt, 1);
    feed_job(1'b0, 2);
    check_burst(1'b0, 2);
    finish_job(1'b0, 1);
    enc_req = 1'b0;
    nxt();
    chk("dec_done_once", dec_done_cnt - d0, 1);

    // Watchdog: core_done withheld
    do_reset();
    d0 = enc_done_cnt;
    job[0] = 16'h0051; job[1] = 16'h0052;
    enc_req = 1'b1; enc_num = 5'd2;
    feed_job(1'b0, 2);
    check_burst(1'b0, 2);
    last = (beat_q.size() >= mark + 2) ? beat_cyc[mark+1] : cyc;
    g = 0;
    while (core_abort !== 1'b1 && g < 1100) begin nxt(); g++; end
    chk("tmo_latency", cyc - last, 1023);
    chk("tmo_err_tmo", err_tmo, 1);
    enc_req = 1'b0;
    nxt();
    chk("tmo_pulse_end", {core_abort, err_tmo}, 0);
    chk("tmo_gnt_low", enc_gnt, 0);
    nxt();
    chk("tmo_stays_idle", {enc_gnt, core_mode}, 0);
    chk("tmo_no_done", enc_done_cnt - d0, 0);

    // Reset asserted mid-burst
    do_reset();
    d0 = enc_done_cnt;
    job[0] = 16'h0048; job[1] = 16'h0045; job[2] = 16'h004C; job[3] = 16'h004C; job[4] = 16'h004F;
    enc_req = 1'b1; enc_num = 5'd5;
    feed_job(1'b0, 5);
    g = 0;
    while (core_code_valid !== 1'b1 && g < 20) begin nxt(); g++; end
    chk("midburst_reached", core_code_valid, 1);
    reset = 1'b1;
    #1;
    chk("midburst_reset_outs", {enc_ready, enc_gnt, enc_done, dec_ready, dec_gnt, dec_done, core_mode,
                                core_code_valid, core_code_pos, core_code_len, core_chardata,
                                core_abort, err_len, err_tmo}, 0);
    enc_req = 1'b0;
    nxt();
    reset = 1'b0;
    mark = beat_q.size();
    repeat (5) nxt();
    chk("post_reset_no_beats", beat_q.size() - mark, 0);
    chk("post_reset_no_done", enc_done_cnt - d0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
